// File: rtl/prog_loader.sv
// UART boot loader: decodes framed program images from an 8N1 serial stream
// and writes each instruction word into program memory, holding the CPU in reset meanwhile.
module prog_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int INSTR_W      = 16,
  parameter int ADDR_W       = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic               cpu_reset,
  output logic               busy,
  output logic               done,
  output logic               err
);
  localparam int BPW = (INSTR_W + 7) / 8;
  localparam int WW  = BPW * 8;
  localparam int CW  = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [7:0] HEADER = 8'hA5;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {IDLE, COUNT, DATA, CHECK} ld_state_t;

  logic rx_meta, rx_sync, rx_prev;
  rx_state_t rs, rs_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] bit_idx, bit_idx_n;
  logic [7:0] shift, shift_n;
  logic byte_valid, frame_err;

  ld_state_t ls, ls_n;
  logic [7:0] left, left_n, csum, csum_n;
  logic [2:0] bidx, bidx_n;
  logic [WW-1:0] word, word_n;
  logic [ADDR_W-1:0] addr_next, addr_next_n, mem_addr_n;
  logic [INSTR_W-1:0] mem_wdata_n;
  logic mem_we_n, cpu_reset_n, busy_n, done_n, err_n;

  // Receiver and loader state registers; reset also clears the synchroniser to line-idle
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_prev   <= 1'b1;
      rs        <= RX_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      ls        <= IDLE;
      left      <= '0;
      csum      <= '0;
      bidx      <= '0;
      word      <= '0;
      addr_next <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_reset <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rx_sync   <= rx_meta;
      rx_prev   <= rx_sync;
      rs        <= rs_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_idx_n;
      shift     <= shift_n;
      ls        <= ls_n;
      left      <= left_n;
      csum      <= csum_n;
      bidx      <= bidx_n;
      word      <= word_n;
      addr_next <= addr_next_n;
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      cpu_reset <= cpu_reset_n;
      busy      <= busy_n;
      done      <= done_n;
      err       <= err_n;
    end
  end

  // Byte receiver: start bit checked at half a bit, data and stop sampled at mid-bit
  always_comb begin
    rs_n       = rs;
    cnt_n      = cnt + CW'(1);
    bit_idx_n  = bit_idx;
    shift_n    = shift;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (rs)
      RX_IDLE: begin
        cnt_n = '0;
        if (rx_prev && !rx_sync) rs_n = RX_START;
      end
      RX_START: if (cnt == HALF) begin
        cnt_n     = '0;
        bit_idx_n = '0;
        rs_n      = rx_sync ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (cnt == FULL) begin
        cnt_n     = '0;
        shift_n   = {rx_sync, shift[7:1]};
        bit_idx_n = bit_idx + 3'd1;
        if (bit_idx == 3'd7) rs_n = RX_STOP;
      end
      RX_STOP: if (cnt == FULL) begin
        cnt_n      = '0;
        rs_n       = RX_IDLE;
        byte_valid = rx_sync;
        frame_err  = !rx_sync;
      end
      default: rs_n = RX_IDLE;
    endcase
  end

  // Frame decoder: all outputs are registered, so they change one cycle after a byte strobe
  always_comb begin
    ls_n        = ls;
    left_n      = left;
    csum_n      = csum;
    bidx_n      = bidx;
    word_n      = word;
    addr_next_n = addr_next;
    mem_we_n    = 1'b0;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    cpu_reset_n = cpu_reset;
    busy_n      = busy;
    done_n      = done;
    err_n       = err;
    if (ls == IDLE) begin
      if (byte_valid && shift == HEADER) begin
        ls_n        = COUNT;
        done_n      = 1'b0;
        err_n       = 1'b0;
        busy_n      = 1'b1;
        cpu_reset_n = 1'b1;
        addr_next_n = '0;
        csum_n      = '0;
        bidx_n      = '0;
        word_n      = '0;
      end
    end else if (frame_err) begin
      ls_n        = IDLE;
      err_n       = 1'b1;
      cpu_reset_n = 1'b1;
      busy_n      = 1'b0;
    end else if (byte_valid) begin
      case (ls)
        COUNT: begin
          if (shift == 8'd0) begin
            ls_n   = IDLE;
            err_n  = 1'b1;
            busy_n = 1'b0;
          end else begin
            left_n = shift;
            ls_n   = DATA;
          end
        end
        DATA: begin
          word_n = (word << 8) | WW'(shift);
          csum_n = csum ^ shift;
          if (bidx == 3'(BPW - 1)) begin
            bidx_n      = '0;
            mem_we_n    = 1'b1;
            mem_addr_n  = addr_next;
            mem_wdata_n = word_n[INSTR_W-1:0];
            addr_next_n = addr_next + ADDR_W'(1);
            if (left == 8'd1) ls_n = CHECK;
            else left_n = left - 8'd1;
          end else begin
            bidx_n = bidx + 3'd1;
          end
        end
        CHECK: begin
          ls_n   = IDLE;
          busy_n = 1'b0;
          if (shift == csum) begin
            done_n      = 1'b1;
            cpu_reset_n = 1'b0;
          end else begin
            err_n = 1'b1;
          end
        end
        default: ls_n = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: serial frames in, expected memory writes scoreboarded
// and compared by an independent monitor; status flags checked after each frame.
module tb_prog_loader;
  localparam int CPB = 4;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;
  typedef logic [7:0] byte_q_t[$];
  typedef logic [15:0] word_q_t[$];

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx = 1'b1;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_reset, busy, done, err;

  wr_t exp_q[$];
  int  checks = 0;
  int  failures = 0;

  prog_loader #(.CLKS_PER_BIT(CPB), .INSTR_W(16), .ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .rx(rx),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, required);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write
  always @(negedge clk) begin : monitor
    wr_t e;
    if (mem_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_write actual=0x%0h/0x%0h required=none", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        check_output("write_addr", 32'(mem_addr), 32'(e.addr));
        check_output("write_data", 32'(mem_wdata), 32'(e.data));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_ok;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic apply_stimulus(input byte_q_t bytes);
    foreach (bytes[i]) send_byte(bytes[i], 1'b1);
    repeat (6) @(negedge clk);
  endtask

  task automatic check_status(input string tag, input logic d, input logic e, input logic c, input logic b);
    check_output({tag, "_done"}, 32'(done), 32'(d));
    check_output({tag, "_err"}, 32'(err), 32'(e));
    check_output({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(c));
    check_output({tag, "_busy"}, 32'(busy), 32'(b));
    check_output({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check_output({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check_output({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    check_status(tag, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Reference model at frame level: words land at consecutive addresses, checksum is XOR of data bytes
  task automatic send_frame(input word_q_t words, input bit corrupt);
    byte_q_t q;
    logic [7:0] x = 8'h00;
    q.push_back(8'hA5);
    q.push_back(8'(words.size()));
    foreach (words[i]) begin
      q.push_back(words[i][15:8]);
      q.push_back(words[i][7:0]);
      x = x ^ words[i][15:8] ^ words[i][7:0];
      exp_q.push_back(wr_t'({8'(i % 256), words[i]}));
    end
    q.push_back(corrupt ? (x ^ 8'(1 + $urandom_range(254))) : x);
    apply_stimulus(q);
    check_status(corrupt ? "rand_bad" : "rand_ok", !corrupt, corrupt, corrupt, 1'b0);
  endtask

  initial begin
    word_q_t w;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("reset");

    $display("[TB] two-word frame");
    exp_q.push_back(wr_t'({8'h00, 16'h1234}));
    exp_q.push_back(wr_t'({8'h01, 16'hABCD}));
    apply_stimulus('{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40});
    check_status("good", 1'b1, 1'b0, 1'b0, 1'b0);

    $display("[TB] bad checksum then recovery");
    exp_q.push_back(wr_t'({8'h00, 16'h1234}));
    exp_q.push_back(wr_t'({8'h01, 16'hABCD}));
    apply_stimulus('{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41});
    check_status("badsum", 1'b0, 1'b1, 1'b1, 1'b0);
    exp_q.push_back(wr_t'({8'h00, 16'h1234}));
    exp_q.push_back(wr_t'({8'h01, 16'hABCD}));
    apply_stimulus('{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40});
    check_status("recover", 1'b1, 1'b0, 1'b0, 1'b0);

    $display("[TB] idle noise");
    apply_stimulus('{8'h00, 8'hFF, 8'h5A});
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (12) @(negedge clk);
    check_status("noise", 1'b1, 1'b0, 1'b0, 1'b0);
    w = '{16'h0F0F, 16'hA5A5, 16'h0001};
    send_frame(w, 1'b0);

    $display("[TB] zero count");
    apply_stimulus('{8'hA5, 8'h00});
    check_status("zero_n", 1'b0, 1'b1, 1'b1, 1'b0);

    $display("[TB] framing error in data");
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h12, 1'b0);
    repeat (8) @(negedge clk);
    check_status("framing", 1'b0, 1'b1, 1'b1, 1'b0);

    $display("[TB] reset mid-frame");
    apply_stimulus('{8'hA5, 8'h02, 8'h12});
    check_output("midframe_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_values("abort");
    exp_q.push_back(wr_t'({8'h00, 16'hBEEF}));
    apply_stimulus('{8'hA5, 8'h01, 8'hBE, 8'hEF, 8'h51});
    check_status("after_abort", 1'b1, 1'b0, 1'b0, 1'b0);

    $display("[TB] randomized frames");
    for (int f = 0; f < 8; f++) begin
      byte_q_t junk;
      int nj = $urandom_range(2);
      for (int j = 0; j < nj; j++) begin
        logic [7:0] jb = 8'($urandom);
        if (jb == 8'hA5) jb = 8'h5A;
        junk.push_back(jb);
      end
      apply_stimulus(junk);
      w = {};
      for (int k = 0; k < 1 + $urandom_range(4); k++) w.push_back(16'($urandom));
      send_frame(w, $urandom_range(3) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
